fetch_pc_ifid: RTL and testbench
================================

// Module: fetch_pc_ifid
// PURPOSE
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC and drives it to the
//   combinational instruction memory. Captures the returned instruction word and PC+4 into the
//   IF/ID pipeline register. Applies stall, flush and branch/jump redirect requests from the
//   ID-stage hazard/branch logic.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   NOP_WORD  32'h0000_0000  bubble word written to IF/ID on flush/redirect (sll $0,$0,0)
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   stall          in   1   hold PC and IF/ID (load-use hazard)
//   flush          in   1   replace IF/ID contents with bubble; PC unaffected
//   branch_taken   in   1   ID-stage branch resolved taken
//   branch_target  in   32  branch destination byte address
//   jump           in   1   ID-stage J/JAL/JR
//   jump_target    in   32  jump destination byte address
//   IR             in   32  instruction word from instruction memory for PC (same cycle)
//   PC             out  32  current fetch address to instruction memory
//   ifid_IR        out  32  IF/ID instruction
//   ifid_PC4       out  32  IF/ID PC+4 of that instruction
//   ifid_valid     out  1   IF/ID holds a real (non-bubble) instruction
// BEHAVIOUR
//   - All state updates on posedge clk. Priority per edge: reset > redirect > stall > normal.
//   - reset=1: PC<=RESET_PC, ifid_IR<=NOP_WORD, ifid_PC4<=0, ifid_valid<=0. Reset mid-operation
//     discards any pending redirect/stall. Outputs follow the reset values from the first edge
//     with reset=1.
//   - Redirect = jump | branch_taken. jump has priority over branch_taken if both are asserted.
//     Redirect: PC<=target with bits[1:0] forced to 2'b00. IF/ID<=bubble (NOP_WORD, valid=0).
//     No delay slot: the wrong-path word in IF is squashed. Redirect overrides stall.
//   - stall=1, no redirect: PC, ifid_IR, ifid_PC4 and ifid_valid hold. If flush is also
//     asserted, flush wins for IF/ID (bubble) and PC still holds.
//   - flush=1, no stall, no redirect: PC<=PC+4, IF/ID<=bubble.
//   - Normal: ifid_IR<=IR, ifid_PC4<=PC+4, ifid_valid<=1, PC<=PC+4.
//   - Latency: the word at PC appears on ifid_IR exactly 1 edge later. After reset release the
//     first valid IF/ID (IR at RESET_PC) appears at the first non-reset edge.
//   - Arithmetic: PC+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 32'h0000_0000 silently.
//   - PC is a registered output, never combinational from inputs.
//   - Bubble ifid_PC4 is 0.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: adds output ports fetch_cnt[31:0], stall_cnt[31:0] and
//   squash_cnt[31:0]. All reset to 0.
//     - fetch_cnt +1 per edge where ifid_valid is written 1.
//     - stall_cnt +1 per edge where stall holds the PC (no redirect, no reset).
//     - squash_cnt +1 per edge where a redirect occurs.
//     - All three wrap modulo 2^32.
//   FETCH_PERF_CNT_EN undefined: these ports and counters do not exist. Behaviour is otherwise
//   identical.
// TESTING
//   1. Reset 2 cycles, then free-run with IR=mem[PC>>2]: PC goes 0,4,8,C. ifid_IR=mem[0] and
//      ifid_PC4=4 after the 1st edge post-reset, valid=1.
//   2. At PC=8, branch_taken=1 with branch_target=32'h40: next edge PC=40, ifid_valid=0,
//      ifid_IR=0. Following edge ifid_IR=mem[16], ifid_PC4=44.
//   3. stall=1 for 3 edges at PC=C: PC stays C and IF/ID is unchanged. Then add jump=1 with
//      jump_target=32'h103 during the stall: PC=100 next edge and IF/ID is a bubble.
//   4. jump=1 (target 32'h200) and branch_taken=1 (target 32'h80) together -> PC=200.
//      stall+flush together -> PC held, ifid_valid=0.
//   5. Force PC to 32'hFFFF_FFFC via jump, then run 1 edge -> PC=0, ifid_PC4=0. Assert reset
//      during a stall -> PC=RESET_PC and valid=0 next edge.
//   6. With FETCH_PERF_CNT_EN, run scenarios 1-3 -> counters match hand count
//      (e.g. stall_cnt=3, squash_cnt=2). Build without the macro -> compiles, no counter ports.

Source files
------------

// File: rtl/fetch_pc_ifid.sv
// rtl/fetch_pc_ifid.sv - MIPS IF stage: PC register, IF/ID pipeline register, stall/flush/redirect.
// Optional FETCH_PERF_CNT_EN adds fetch/stall/squash event counters.
module fetch_pc_ifid #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] IR,
  output logic [31:0] PC,
  output logic [31:0] ifid_IR,
  output logic [31:0] ifid_PC4,
  output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] squash_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;

  assign redirect    = jump | branch_taken;
  // Jump wins over a simultaneous taken branch; targets are word-aligned.
  assign redirect_pc = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
  assign pc_plus4    = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      ir_d    = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (stall) begin
      if (flush) begin
        ir_d    = NOP_WORD;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end
    end else if (flush) begin
      pc_d    = pc_plus4;
      ir_d    = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      ir_d    = IR;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign PC         = pc_q;
  assign ifid_IR    = ir_q;
  assign ifid_PC4   = pc4_q;
  assign ifid_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (valid_d) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall && !redirect) stall_cnt_d = stall_cnt_q + 32'd1;
    if (redirect) squash_cnt_d = squash_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 32'd0;
      stall_cnt_q  <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// tb/tb_fetch_pc_ifid.sv - directed bench for fetch_pc_ifid; instruction memory returns ~address.
module tb_fetch_pc_ifid;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic [31:0] IR;
  logic [31:0] PC;
  logic [31:0] ifid_IR;
  logic [31:0] ifid_PC4;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, squash_cnt;
`endif

  int checks = 0;
  int errors = 0;

  assign IR = ~PC;

  always #5 clk = ~clk;

  fetch_pc_ifid dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .IR(IR), .PC(PC),
    .ifid_IR(ifid_IR), .ifid_PC4(ifid_PC4), .ifid_valid(ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
`endif
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    reset = 0; stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
  endtask

  task automatic test_reset();
    clear_ctl();
    reset = 1;
    jump = 1; jump_target = 32'h0000_0500;
    edge1();
    edge1();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", PC, 32'h0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_IR !== 32'h0) begin errors++; $display("FAIL reset_ir got %h exp 0", ifid_IR); end
    checks++; if (ifid_PC4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", ifid_PC4); end
    clear_ctl();
  endtask

  task automatic test_free_run();
    edge1();
    checks++; if (PC !== 32'h4) begin errors++; $display("FAIL run1_pc got %h exp 4", PC); end
    checks++; if (ifid_IR !== 32'hFFFF_FFFF) begin errors++; $display("FAIL run1_ir got %h exp ffffffff", ifid_IR); end
    checks++; if (ifid_PC4 !== 32'h4) begin errors++; $display("FAIL run1_pc4 got %h exp 4", ifid_PC4); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL run1_valid got %b exp 1", ifid_valid); end
    edge1();
    checks++; if (PC !== 32'h8) begin errors++; $display("FAIL run2_pc got %h exp 8", PC); end
    checks++; if (ifid_IR !== 32'hFFFF_FFFB) begin errors++; $display("FAIL run2_ir got %h exp fffffffb", ifid_IR); end
    checks++; if (ifid_PC4 !== 32'h8) begin errors++; $display("FAIL run2_pc4 got %h exp 8", ifid_PC4); end
  endtask

  task automatic test_branch();
    branch_taken = 1; branch_target = 32'h40;
    edge1();
    checks++; if (PC !== 32'h40) begin errors++; $display("FAIL br_pc got %h exp 40", PC); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_IR !== 32'h0) begin errors++; $display("FAIL br_ir got %h exp 0", ifid_IR); end
    checks++; if (ifid_PC4 !== 32'h0) begin errors++; $display("FAIL br_pc4 got %h exp 0", ifid_PC4); end
    clear_ctl();
    edge1();
    checks++; if (PC !== 32'h44) begin errors++; $display("FAIL br2_pc got %h exp 44", PC); end
    checks++; if (ifid_IR !== 32'hFFFF_FFBF) begin errors++; $display("FAIL br2_ir got %h exp ffffffbf", ifid_IR); end
    checks++; if (ifid_PC4 !== 32'h44) begin errors++; $display("FAIL br2_pc4 got %h exp 44", ifid_PC4); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL br2_valid got %b exp 1", ifid_valid); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL br_fetch_cnt got %0d exp 3", fetch_cnt); end
    checks++; if (squash_cnt !== 32'd1) begin errors++; $display("FAIL br_squash_cnt got %0d exp 1", squash_cnt); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL br_stall_cnt got %0d exp 0", stall_cnt); end
`endif
  endtask

  task automatic test_stall();
    reset = 1;
    edge1();
    clear_ctl();
    edge1(); edge1(); edge1();
    checks++; if (PC !== 32'hC) begin errors++; $display("FAIL st_pre_pc got %h exp c", PC); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++; if (PC !== 32'hC) begin errors++; $display("FAIL st_pc[%0d] got %h exp c", i, PC); end
      checks++; if (ifid_IR !== 32'hFFFF_FFF7) begin errors++; $display("FAIL st_ir[%0d] got %h exp fffffff7", i, ifid_IR); end
      checks++; if (ifid_PC4 !== 32'hC) begin errors++; $display("FAIL st_pc4[%0d] got %h exp c", i, ifid_PC4); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL st_valid[%0d] got %b exp 1", i, ifid_valid); end
    end
    jump = 1; jump_target = 32'h103;
    edge1();
    checks++; if (PC !== 32'h100) begin errors++; $display("FAIL st_jmp_pc got %h exp 100", PC); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL st_jmp_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_IR !== 32'h0) begin errors++; $display("FAIL st_jmp_ir got %h exp 0", ifid_IR); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL st_fetch_cnt got %0d exp 3", fetch_cnt); end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL st_stall_cnt got %0d exp 3", stall_cnt); end
    checks++; if (squash_cnt !== 32'd1) begin errors++; $display("FAIL st_squash_cnt got %0d exp 1", squash_cnt); end
`endif
    clear_ctl();
  endtask

  task automatic test_priority();
    jump = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h80;
    edge1();
    checks++; if (PC !== 32'h200) begin errors++; $display("FAIL pri_pc got %h exp 200", PC); end
    clear_ctl();
    edge1();
    checks++; if (ifid_IR !== 32'hFFFF_FDFF) begin errors++; $display("FAIL pri_ir got %h exp fffffdff", ifid_IR); end
    checks++; if (ifid_PC4 !== 32'h204) begin errors++; $display("FAIL pri_pc4 got %h exp 204", ifid_PC4); end
    stall = 1; flush = 1;
    edge1();
    checks++; if (PC !== 32'h204) begin errors++; $display("FAIL sf_pc got %h exp 204", PC); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL sf_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_PC4 !== 32'h0) begin errors++; $display("FAIL sf_pc4 got %h exp 0", ifid_PC4); end
    stall = 0;
    edge1();
    checks++; if (PC !== 32'h208) begin errors++; $display("FAIL fl_pc got %h exp 208", PC); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %b exp 0", ifid_valid); end
    clear_ctl();
  endtask

  task automatic test_wrap_and_reset();
    jump = 1; jump_target = 32'hFFFF_FFFC;
    edge1();
    checks++; if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pre_pc got %h exp fffffffc", PC); end
    clear_ctl();
    edge1();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wr_pc got %h exp 0", PC); end
    checks++; if (ifid_PC4 !== 32'h0) begin errors++; $display("FAIL wr_pc4 got %h exp 0", ifid_PC4); end
    checks++; if (ifid_IR !== 32'h0000_0003) begin errors++; $display("FAIL wr_ir got %h exp 3", ifid_IR); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL wr_valid got %b exp 1", ifid_valid); end
    edge1(); edge1();
    stall = 1;
    edge1();
    reset = 1;
    edge1();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_st_pc got %h exp 0", PC); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_st_valid got %b exp 0", ifid_valid); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
`endif
    clear_ctl();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch();
    test_stall();
    test_priority();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
